// File: rtl/stepper_phase_seq_pkg.sv
// rtl/stepper_phase_seq_pkg.sv - shared types, phase table and index stepping for the stepper sequencer
package stepper_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_STEP = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  localparam int POS_W_DEF = 32;

  // Coil drive {D,C,B,A}; entry 0 sits in the low nibble.
  localparam logic [7:0][3:0] PHASE_TBL = {
    4'b1001, 4'b1000, 4'b1100, 4'b0100,
    4'b0110, 4'b0010, 4'b0011, 4'b0001
  };

  // Full-step from an even (single-coil) index moves by one to realign to a two-coil pattern.
  function automatic logic [2:0] next_idx(input logic [2:0] idx, input logic dir, input logic half);
    logic [2:0] inc;
    inc = (half || !idx[0]) ? 3'd1 : 3'd2;
    return dir ? (idx + inc) : (idx - inc);
  endfunction

endpackage

// File: rtl/stepper_phase_seq_if.sv
// rtl/stepper_phase_seq_if.sv - step command inputs and coil/position outputs of the stepper sequencer
interface stepper_phase_seq_if
  import stepper_pkg::*;
#(
  parameter int POS_W = POS_W_DEF
);
  logic                    ST_CLK;
  logic                    ST_DIR;
  logic                    ST_ENB;
  logic                    ST_DIS;
  logic                    HALF;
  logic                    CLR;
  logic [3:0]              PHASE;
  logic signed [POS_W-1:0] POS;
  logic                    BUSY;
  logic                    OVR;
  logic                    LIMIT;

  modport master (
    output ST_CLK, ST_DIR, ST_ENB, ST_DIS, HALF, CLR,
    input  PHASE, POS, BUSY, OVR, LIMIT
  );

  modport slave (
    input  ST_CLK, ST_DIR, ST_ENB, ST_DIS, HALF, CLR,
    output PHASE, POS, BUSY, OVR, LIMIT
  );
endinterface

// File: rtl/stepper_phase_seq_sync.sv
// rtl/stepper_phase_seq_sync.sv - two-flop synchroniser plus history flop giving a one-cycle rising-edge pulse
module step_edge_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic async_i,
  output logic edge_o
);
  logic s1_q, s2_q, s3_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= async_i;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign edge_o = s2_q & ~s3_q;
endmodule

// File: rtl/stepper_phase_seq.sv
// rtl/stepper_phase_seq.sv - 4-coil unipolar stepper phase sequencer with position, overrun and optional soft limit (STEP_POS_LIMIT_EN)
module stepper_phase_seq
  import stepper_pkg::*;
#(
  parameter int HOLD_CYC = 16,
  parameter int POS_W    = POS_W_DEF,
  parameter int POS_MIN  = -100000,
  parameter int POS_MAX  = 100000
) (
  input logic                LClk,
  input logic                LRst,
  stepper_phase_seq_if.slave bus
);
  localparam int HCW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;

  state_e                  state_q;
  logic [2:0]              idx_q, idx_d;
  logic signed [POS_W-1:0] pos_q, pos_d;
  logic [3:0]              phase_q;
  logic [HCW-1:0]          hold_q;
  logic                    ovr_q;
  logic                    step_req;
  logic                    en;
  logic                    do_step;
  logic                    ovr_set;
  logic                    lim_hit;

  step_edge_sync u_sync (
    .clk_i   (LClk),
    .rst_i   (LRst),
    .async_i (bus.ST_CLK),
    .edge_o  (step_req)
  );

`ifdef STEP_POS_LIMIT_EN
  localparam logic signed [63:0] PMIN = 64'(POS_MIN);
  localparam logic signed [63:0] PMAX = 64'(POS_MAX);
  logic signed [63:0] pos_ext;
  logic               lim_q;
  logic               lim_set;

  // Widened so the +/-1 probe cannot itself overflow at the POS_W extremes.
  assign pos_ext = 64'(pos_q);
  assign lim_hit = bus.ST_DIR ? ((pos_ext + 64'sd1) > PMAX) : ((pos_ext - 64'sd1) < PMIN);
  assign lim_set = step_req & en & (state_q == ST_IDLE) & lim_hit;

  always_ff @(posedge LClk) begin
    if (LRst) begin
      lim_q <= 1'b0;
    end else if (lim_set) begin
      lim_q <= 1'b1;
    end else if (bus.CLR) begin
      lim_q <= 1'b0;
    end
  end

  assign bus.LIMIT = lim_q;
`else
  assign lim_hit   = 1'b0;
  assign bus.LIMIT = 1'b0;
`endif

  always_comb begin
    en      = bus.ST_ENB & ~bus.ST_DIS;
    do_step = (state_q == ST_STEP) & en;
    ovr_set = step_req & en & (state_q != ST_IDLE);
    idx_d   = idx_q;
    pos_d   = pos_q;
    if (do_step) begin
      idx_d = next_idx(idx_q, bus.ST_DIR, bus.HALF);
      pos_d = bus.ST_DIR ? (pos_q + POS_W'(1)) : (pos_q - POS_W'(1));
    end
  end

  always_ff @(posedge LClk) begin
    if (LRst) begin
      state_q <= ST_IDLE;
      idx_q   <= 3'd0;
      pos_q   <= '0;
      phase_q <= 4'b0000;
      hold_q  <= '0;
      ovr_q   <= 1'b0;
    end else begin
      idx_q   <= idx_d;
      pos_q   <= pos_d;
      phase_q <= en ? PHASE_TBL[idx_d] : 4'b0000;

      if (ovr_set) begin
        ovr_q <= 1'b1;
      end else if (bus.CLR) begin
        ovr_q <= 1'b0;
      end

      case (state_q)
        ST_IDLE: begin
          if (step_req && en && !lim_hit) begin
            state_q <= ST_STEP;
          end
        end
        ST_STEP: begin
          if (en) begin
            state_q <= ST_HOLD;
            hold_q  <= HCW'(HOLD_CYC - 1);
          end else begin
            state_q <= ST_IDLE;
            hold_q  <= '0;
          end
        end
        ST_HOLD: begin
          if (!en || hold_q == '0) begin
            state_q <= ST_IDLE;
            hold_q  <= '0;
          end else begin
            hold_q <= hold_q - HCW'(1);
          end
        end
        default: begin
          state_q <= ST_IDLE;
          hold_q  <= '0;
        end
      endcase
    end
  end

  assign bus.PHASE = phase_q;
  assign bus.POS   = pos_q;
  assign bus.BUSY  = (state_q != ST_IDLE);
  assign bus.OVR   = ovr_q;
endmodule

// File: tb/tb_stepper_phase_seq.sv
// tb/tb_stepper_phase_seq.sv - directed self-checking bench for stepper_phase_seq
module tb_stepper_phase_seq;
  logic clk;
  logic rst;
  int   pass_cnt;
  int   total_cnt;

`ifdef STEP_POS_LIMIT_EN
  localparam bit LIM_ON = 1'b1;
`else
  localparam bit LIM_ON = 1'b0;
`endif

  stepper_phase_seq_if #(.POS_W(32)) a_if ();
  stepper_phase_seq_if #(.POS_W(8))  b_if ();
  stepper_phase_seq_if #(.POS_W(32)) c_if ();

  stepper_phase_seq #(.HOLD_CYC(16), .POS_W(32), .POS_MIN(-100000), .POS_MAX(100000)) u_a (
    .LClk(clk), .LRst(rst), .bus(a_if)
  );
  stepper_phase_seq #(.HOLD_CYC(1), .POS_W(8), .POS_MIN(-100000), .POS_MAX(100000)) u_b (
    .LClk(clk), .LRst(rst), .bus(b_if)
  );
  stepper_phase_seq #(.HOLD_CYC(4), .POS_W(32), .POS_MIN(-2), .POS_MAX(2)) u_c (
    .LClk(clk), .LRst(rst), .bus(c_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic init_inputs();
    a_if.ST_CLK = 0; a_if.ST_DIR = 1; a_if.ST_ENB = 1; a_if.ST_DIS = 0; a_if.HALF = 1; a_if.CLR = 0;
    b_if.ST_CLK = 0; b_if.ST_DIR = 1; b_if.ST_ENB = 1; b_if.ST_DIS = 0; b_if.HALF = 1; b_if.CLR = 0;
    c_if.ST_CLK = 0; c_if.ST_DIR = 1; c_if.ST_ENB = 1; c_if.ST_DIS = 0; c_if.HALF = 1; c_if.CLR = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic step_a();
    @(negedge clk);
    a_if.ST_CLK = 1'b1;
    repeat (4) @(negedge clk);
    a_if.ST_CLK = 1'b0;
    repeat (36) @(negedge clk);
  endtask

  task automatic step_c(input logic dir);
    @(negedge clk);
    c_if.ST_DIR = dir;
    c_if.ST_CLK = 1'b1;
    repeat (3) @(negedge clk);
    c_if.ST_CLK = 1'b0;
    repeat (17) @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total_cnt++; if (a_if.PHASE !== 4'b0000) $display("FAIL rst_phase: got %b expected 0000", a_if.PHASE); else pass_cnt++;
    total_cnt++; if (a_if.POS !== 32'sd0) $display("FAIL rst_pos: got %0d expected 0", a_if.POS); else pass_cnt++;
    total_cnt++; if (a_if.BUSY !== 1'b0) $display("FAIL rst_busy: got %b expected 0", a_if.BUSY); else pass_cnt++;
    total_cnt++; if (a_if.OVR !== 1'b0) $display("FAIL rst_ovr: got %b expected 0", a_if.OVR); else pass_cnt++;
    total_cnt++; if (a_if.LIMIT !== 1'b0) $display("FAIL rst_limit: got %b expected 0", a_if.LIMIT); else pass_cnt++;
    rst = 1'b0;
    @(negedge clk);
    total_cnt++; if (a_if.PHASE !== 4'b0001) $display("FAIL rst_en_phase: got %b expected 0001", a_if.PHASE); else pass_cnt++;
  endtask

  task automatic test_half_fwd();
    @(negedge clk);
    a_if.ST_CLK = 1'b1;
    for (int e = 0; e < 3; e++) begin
      @(posedge clk); #1;
      total_cnt++; if (a_if.PHASE !== 4'b0001) $display("FAIL latency_edge_k%0d: got %b expected 0001", e, a_if.PHASE); else pass_cnt++;
    end
    total_cnt++; if (a_if.BUSY !== 1'b1) $display("FAIL busy_in_step: got %b expected 1", a_if.BUSY); else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++; if (a_if.PHASE !== 4'b0011) $display("FAIL first_change_k3: got %b expected 0011", a_if.PHASE); else pass_cnt++;
    total_cnt++; if (a_if.POS !== 32'sd1) $display("FAIL first_pos_k3: got %0d expected 1", a_if.POS); else pass_cnt++;
    repeat (2) @(negedge clk);
    a_if.ST_CLK = 1'b0;
    repeat (34) @(negedge clk);
    step_a();
    total_cnt++; if (a_if.PHASE !== 4'b0010) $display("FAIL half_step2: got %b expected 0010", a_if.PHASE); else pass_cnt++;
    step_a();
    total_cnt++; if (a_if.PHASE !== 4'b0110) $display("FAIL half_step3: got %b expected 0110", a_if.PHASE); else pass_cnt++;
    total_cnt++; if (a_if.POS !== 32'sd3) $display("FAIL half_pos3: got %0d expected 3", a_if.POS); else pass_cnt++;
    total_cnt++; if (a_if.OVR !== 1'b0) $display("FAIL half_ovr: got %b expected 0", a_if.OVR); else pass_cnt++;
    total_cnt++; if (a_if.BUSY !== 1'b0) $display("FAIL half_idle: got %b expected 0", a_if.BUSY); else pass_cnt++;
  endtask

  task automatic test_full_rev();
    a_if.HALF = 1'b0;
    a_if.ST_DIR = 1'b0;
    do_reset();
    step_a();
    total_cnt++; if (a_if.PHASE !== 4'b1001) $display("FAIL full_rev1: got %b expected 1001", a_if.PHASE); else pass_cnt++;
    step_a();
    total_cnt++; if (a_if.PHASE !== 4'b1100) $display("FAIL full_rev2: got %b expected 1100", a_if.PHASE); else pass_cnt++;
    total_cnt++; if (a_if.POS !== -32'sd2) $display("FAIL full_rev_pos: got %0d expected -2", a_if.POS); else pass_cnt++;
  endtask

  task automatic test_overrun();
    a_if.HALF = 1'b1;
    a_if.ST_DIR = 1'b1;
    do_reset();
    a_if.ST_CLK = 1'b1;
    repeat (3) @(negedge clk);
    a_if.ST_CLK = 1'b0;
    repeat (3) @(negedge clk);
    a_if.ST_CLK = 1'b1;
    repeat (3) @(negedge clk);
    a_if.ST_CLK = 1'b0;
    repeat (40) @(negedge clk);
    total_cnt++; if (a_if.OVR !== 1'b1) $display("FAIL ovr_set: got %b expected 1", a_if.OVR); else pass_cnt++;
    total_cnt++; if (a_if.POS !== 32'sd1) $display("FAIL ovr_pos: got %0d expected 1", a_if.POS); else pass_cnt++;
    total_cnt++; if (a_if.PHASE !== 4'b0011) $display("FAIL ovr_phase: got %b expected 0011", a_if.PHASE); else pass_cnt++;
    a_if.CLR = 1'b1;
    @(negedge clk);
    a_if.CLR = 1'b0;
    total_cnt++; if (a_if.OVR !== 1'b0) $display("FAIL ovr_clr: got %b expected 0", a_if.OVR); else pass_cnt++;
  endtask

  task automatic test_disable();
    step_a();
    total_cnt++; if (a_if.PHASE !== 4'b0010) $display("FAIL dis_pre_phase: got %b expected 0010", a_if.PHASE); else pass_cnt++;
    @(negedge clk);
    a_if.ST_DIS = 1'b1;
    @(posedge clk); #1;
    total_cnt++; if (a_if.PHASE !== 4'b0000) $display("FAIL dis_phase_off: got %b expected 0000", a_if.PHASE); else pass_cnt++;
    step_a();
    step_a();
    total_cnt++; if (a_if.POS !== 32'sd2) $display("FAIL dis_pos_held: got %0d expected 2", a_if.POS); else pass_cnt++;
    total_cnt++; if (a_if.OVR !== 1'b0) $display("FAIL dis_no_ovr: got %b expected 0", a_if.OVR); else pass_cnt++;
    total_cnt++; if (a_if.BUSY !== 1'b0) $display("FAIL dis_not_busy: got %b expected 0", a_if.BUSY); else pass_cnt++;
    @(negedge clk);
    a_if.ST_DIS = 1'b0;
    @(posedge clk); #1;
    total_cnt++; if (a_if.PHASE !== 4'b0010) $display("FAIL dis_restore: got %b expected 0010", a_if.PHASE); else pass_cnt++;
    step_a();
    total_cnt++; if (a_if.PHASE !== 4'b0110) $display("FAIL dis_resume_phase: got %b expected 0110", a_if.PHASE); else pass_cnt++;
    total_cnt++; if (a_if.POS !== 32'sd3) $display("FAIL dis_resume_pos: got %0d expected 3", a_if.POS); else pass_cnt++;
  endtask

  task automatic test_wrap();
    for (int s = 0; s < 128; s++) begin
      @(negedge clk);
      b_if.ST_CLK = 1'b1;
      repeat (3) @(negedge clk);
      b_if.ST_CLK = 1'b0;
      repeat (2) @(negedge clk);
      if (s == 126) begin
        repeat (4) @(negedge clk);
        total_cnt++; if (b_if.POS !== 8'sd127) $display("FAIL wrap_pre: got %0d expected 127", b_if.POS); else pass_cnt++;
      end
    end
    repeat (6) @(negedge clk);
    total_cnt++; if (b_if.POS !== 8'h80) $display("FAIL wrap_pos: got %0d expected -128", b_if.POS); else pass_cnt++;
    total_cnt++; if (b_if.OVR !== 1'b0) $display("FAIL wrap_ovr: got %b expected 0", b_if.OVR); else pass_cnt++;
    total_cnt++; if (b_if.PHASE !== 4'b0001) $display("FAIL wrap_phase: got %b expected 0001", b_if.PHASE); else pass_cnt++;
  endtask

  task automatic test_limit();
    logic [31:0] exp_pos;
    logic [3:0]  exp_ph;
    step_c(1'b1);
    step_c(1'b1);
    total_cnt++; if (c_if.POS !== 32'sd2) $display("FAIL lim_pos2: got %0d expected 2", c_if.POS); else pass_cnt++;
    step_c(1'b1);
    exp_pos = LIM_ON ? 32'd2 : 32'd3;
    exp_ph  = LIM_ON ? 4'b0010 : 4'b0110;
    total_cnt++; if (c_if.POS !== exp_pos) $display("FAIL lim_pos3: got %0d expected %0d", c_if.POS, exp_pos); else pass_cnt++;
    total_cnt++; if (c_if.PHASE !== exp_ph) $display("FAIL lim_phase3: got %b expected %b", c_if.PHASE, exp_ph); else pass_cnt++;
    total_cnt++; if (c_if.LIMIT !== LIM_ON) $display("FAIL lim_flag: got %b expected %b", c_if.LIMIT, LIM_ON); else pass_cnt++;
    total_cnt++; if (c_if.OVR !== 1'b0) $display("FAIL lim_ovr: got %b expected 0", c_if.OVR); else pass_cnt++;
    step_c(1'b0);
    exp_pos = LIM_ON ? 32'd1 : 32'd2;
    exp_ph  = LIM_ON ? 4'b0011 : 4'b0010;
    total_cnt++; if (c_if.POS !== exp_pos) $display("FAIL lim_back_pos: got %0d expected %0d", c_if.POS, exp_pos); else pass_cnt++;
    total_cnt++; if (c_if.PHASE !== exp_ph) $display("FAIL lim_back_phase: got %b expected %b", c_if.PHASE, exp_ph); else pass_cnt++;
    @(negedge clk);
    c_if.CLR = 1'b1;
    @(negedge clk);
    c_if.CLR = 1'b0;
    total_cnt++; if (c_if.LIMIT !== 1'b0) $display("FAIL lim_clr: got %b expected 0", c_if.LIMIT); else pass_cnt++;
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    rst       = 1'b1;
    init_inputs();
    test_reset();
    test_half_fwd();
    test_full_rev();
    test_overrun();
    test_disable();
    test_wrap();
    test_limit();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
